// File: rtl/axis_trim_front_realign.sv
// axis_trim_front_realign
// Removes a leading byte count from every packet of a flattened AXI Stream and
// realigns the remaining bytes so that each output beat is full except the
// tlast beat. The trim count is either static or taken per packet from tuser,
// and the tuser length field can be reduced by the trimmed amount.

module axis_trim_front_realign #(
  parameter int TDATA_WIDTH     = 256,
  parameter int TUSER_WIDTH     = 128,
  parameter int BYTES_TRIMMED   = 0,
  parameter int TRIM_FROM_TUSER = 0,
  parameter int TRIM_LSB        = 32,
  parameter int LEN_ADJUST      = 1
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic [TDATA_WIDTH-1:0]   axis_original_tdata,
  input  logic [TDATA_WIDTH/8-1:0] axis_original_tkeep,
  input  logic [TUSER_WIDTH-1:0]   axis_original_tuser,
  input  logic                     axis_original_tvalid,
  output logic                     axis_original_tready,
  input  logic                     axis_original_tlast,
  output logic [TDATA_WIDTH-1:0]   axis_trimmed_tdata,
  output logic [TDATA_WIDTH/8-1:0] axis_trimmed_tkeep,
  output logic [TUSER_WIDTH-1:0]   axis_trimmed_tuser,
  output logic                     axis_trimmed_tvalid,
  input  logic                     axis_trimmed_tready,
  output logic                     axis_trimmed_tlast,
  output logic                     pkt_dropped
);

  localparam int W   = TDATA_WIDTH / 8;          // bytes per beat
  localparam int LW  = $clog2(W);                // byte-offset width
  localparam int CW  = LW + 1;                   // byte-count width (0..W)
  localparam int SHW = $clog2(TDATA_WIDTH) + 1;  // bit-shift amount width

  localparam logic [2:0] ST_FIRST = 3'd0;
  localparam logic [2:0] ST_DROP  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PASS  = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_FLUSH = 3'd5;

  // Contiguous keep mask with cnt low bits set.
  function automatic logic [W-1:0] keep_of(input logic [CW-1:0] cnt);
    logic [W-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < W; i++) begin
      k[i] = (i < 32'(cnt));
    end
    return k;
  endfunction

  // Number of set bits in a keep mask.
  function automatic logic [CW-1:0] count_of(input logic [W-1:0] keep);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < W; i++) begin
      n = n + CW'(keep[i]);
    end
    return n;
  endfunction

  // Zero every data byte whose keep bit is clear.
  function automatic logic [TDATA_WIDTH-1:0] mask_bytes(input logic [TDATA_WIDTH-1:0] data,
                                                        input logic [W-1:0]           keep);
    logic [TDATA_WIDTH-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < W; i++) begin
      d[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
    return d;
  endfunction

  // Packet context
  logic [2:0]             state;
  logic [15:0]            beat_cnt;
  logic [15:0]            drop_beats;
  logic [LW-1:0]          offset;
  logic [TUSER_WIDTH-1:0] user_q;
  logic [TDATA_WIDTH-1:0] residue;
  logic [CW-1:0]          flush_cnt;

  // Output stage
  logic [TDATA_WIDTH-1:0] out_data;
  logic [W-1:0]           out_keep;
  logic [TUSER_WIDTH-1:0] out_user;
  logic                   out_valid;
  logic                   out_last;
  logic                   drop_q;

  // Combinational helpers
  logic                   can_accept;
  logic                   in_ready;
  logic                   in_fire;
  logic [15:0]            trim_in;
  logic [TUSER_WIDTH-1:0] user_in_adj;
  logic [15:0]            cur_drop;
  logic [LW-1:0]          cur_off;
  logic [TUSER_WIDTH-1:0] cur_user;
  logic [CW-1:0]          n_in;
  logic [CW-1:0]          off_ext;
  logic [CW-1:0]          res_cnt;
  logic [SHW-1:0]         off_sh;
  logic [SHW-1:0]         res_sh;
  logic [TDATA_WIDTH-1:0] in_masked;
  logic [TDATA_WIDTH-1:0] realigned;
  logic [TDATA_WIDTH-1:0] shifted;

  // Next-state / emit decisions
  logic [2:0]             nxt_state;
  logic                   load_mode;
  logic                   emit;
  logic [TDATA_WIDTH-1:0] emit_data;
  logic [CW-1:0]          emit_cnt;
  logic                   emit_last;
  logic                   drop_pulse;
  logic [TDATA_WIDTH-1:0] nxt_residue;
  logic [CW-1:0]          nxt_flush;

  assign can_accept = !out_valid || axis_trimmed_tready;
  assign in_ready   = axis_resetn && can_accept && (state != ST_FLUSH);
  assign in_fire    = axis_original_tvalid && in_ready;

  // Trim count of the packet whose first beat is on the input now
  always_comb begin
    trim_in = 16'(BYTES_TRIMMED);
    if (TRIM_FROM_TUSER != 0) begin
      trim_in = axis_original_tuser[TRIM_LSB +: 16];
    end
  end

  // First-beat tuser with the length field reduced by the trim, saturating at 0
  always_comb begin
    user_in_adj = axis_original_tuser;
    if (LEN_ADJUST != 0) begin
      user_in_adj[15:0] = (axis_original_tuser[15:0] > trim_in) ?
                          (axis_original_tuser[15:0] - trim_in) : 16'h0000;
    end
  end

  // In FIRST the packet parameters come straight from the input beat;
  // afterwards from the values latched on that beat.
  always_comb begin
    cur_drop  = (state == ST_FIRST) ? (trim_in >> LW) : drop_beats;
    cur_off   = (state == ST_FIRST) ? trim_in[LW-1:0] : offset;
    cur_user  = (state == ST_FIRST) ? user_in_adj : user_q;
    n_in      = count_of(axis_original_tkeep);
    in_masked = mask_bytes(axis_original_tdata, axis_original_tkeep);
    off_ext   = {1'b0, cur_off};
    res_cnt   = CW'(W) - off_ext;
    off_sh    = {1'b0, cur_off, 3'b000};
    res_sh    = {res_cnt, 3'b000};
    realigned = in_masked >> off_sh;
    shifted   = residue | (in_masked << res_sh);
  end

  // Packet FSM: decides what each accepted beat produces.
  // FIRST with no whole beats to drop is handled as the LOAD beat itself.
  always_comb begin
    nxt_state   = state;
    load_mode   = 1'b0;
    emit        = 1'b0;
    emit_data   = '0;
    emit_cnt    = '0;
    emit_last   = 1'b0;
    drop_pulse  = 1'b0;
    nxt_residue = residue;
    nxt_flush   = flush_cnt;
    case (state)
      ST_FIRST: begin
        if (in_fire) begin
          if (cur_drop != 16'd0) begin
            if (axis_original_tlast) begin
              drop_pulse = 1'b1;
            end else if (cur_drop == 16'd1) begin
              nxt_state = ST_LOAD;
            end else begin
              nxt_state = ST_DROP;
            end
          end else begin
            load_mode = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (in_fire) begin
          if (axis_original_tlast) begin
            drop_pulse = 1'b1;
            nxt_state  = ST_FIRST;
          end else if (beat_cnt + 16'd1 == drop_beats) begin
            nxt_state = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_fire) begin
          load_mode = 1'b1;
        end
      end
      ST_PASS: begin
        if (in_fire) begin
          emit      = 1'b1;
          emit_data = in_masked;
          emit_cnt  = n_in;
          emit_last = axis_original_tlast;
          if (axis_original_tlast) begin
            nxt_state = ST_FIRST;
          end
        end
      end
      ST_SHIFT: begin
        if (in_fire) begin
          emit      = 1'b1;
          emit_data = shifted;
          if (axis_original_tlast && (n_in <= off_ext)) begin
            emit_cnt    = res_cnt + n_in;
            emit_last   = 1'b1;
            nxt_residue = '0;
            nxt_state   = ST_FIRST;
          end else begin
            emit_cnt    = CW'(W);
            nxt_residue = realigned;
            if (axis_original_tlast) begin
              nxt_flush = n_in - off_ext;
              nxt_state = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (can_accept) begin
          emit        = 1'b1;
          emit_data   = residue;
          emit_cnt    = flush_cnt;
          emit_last   = 1'b1;
          nxt_residue = '0;
          nxt_state   = ST_FIRST;
        end
      end
      default: begin
        nxt_state = ST_FIRST;
      end
    endcase

    if (load_mode) begin
      if (cur_off == '0) begin
        emit      = 1'b1;
        emit_data = in_masked;
        emit_cnt  = n_in;
        emit_last = axis_original_tlast;
        nxt_state = axis_original_tlast ? ST_FIRST : ST_PASS;
      end else if (axis_original_tlast) begin
        nxt_state = ST_FIRST;
        if (n_in <= off_ext) begin
          drop_pulse = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_data = realigned;
          emit_cnt  = n_in - off_ext;
          emit_last = 1'b1;
        end
      end else begin
        nxt_residue = realigned;
        nxt_state   = ST_SHIFT;
      end
    end
  end

  // Packet context registers: state, dropped-beat counter and first-beat latches
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= ST_FIRST;
      beat_cnt   <= '0;
      drop_beats <= '0;
      offset     <= '0;
      user_q     <= '0;
    end else begin
      state <= nxt_state;
      if (in_fire && (state == ST_FIRST)) begin
        drop_beats <= cur_drop;
        offset     <= cur_off;
        user_q     <= user_in_adj;
        beat_cnt   <= 16'd1;
      end else if (in_fire && (state == ST_DROP)) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  // Residue bytes carried between beats and the byte count of the flush beat
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      residue   <= '0;
      flush_cnt <= '0;
    end else begin
      residue   <= nxt_residue;
      flush_cnt <= nxt_flush;
    end
  end

  // Registered output stage; only loaded when empty or being drained
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= emit_data;
      out_keep  <= keep_of(emit_cnt);
      out_user  <= cur_user;
      out_last  <= emit_last;
    end else if (axis_trimmed_tready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle pulse for a packet consumed entirely by the trim
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_pulse;
    end
  end

  assign axis_original_tready = in_ready;
  assign axis_trimmed_tdata   = out_data;
  assign axis_trimmed_tkeep   = out_keep;
  assign axis_trimmed_tuser   = out_user;
  assign axis_trimmed_tvalid  = out_valid;
  assign axis_trimmed_tlast   = out_last;
  assign pkt_dropped          = drop_q;

endmodule
